// File: rtl/z80_pkg.sv
// Shared types and defaults for the z80 memory-side bus slave.
package z80_pkg;

    // Bus-cycle sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        HOLD = 2'd3
    } mem_state_t;

    // Direction of the latched access
    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } mem_dir_t;

    localparam int unsigned DEPTH_DEF       = 16384;
    localparam int unsigned WAIT_CYCLES_DEF = 1;
    localparam logic [15:0] ROM_TOP_DEF     = 16'h4000;

endpackage

// File: rtl/z80_mem_ram.sv
// Single-port synchronous byte RAM: write enable, registered read.
// The read register samples every cycle; a write returns the old byte.
module z80_mem_ram #(
    parameter int unsigned DEPTH = 16384
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [7:0]               wdata_i,
    output logic [7:0]               rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Storage write and registered read port (contents are never reset)
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/z80_mem_ctrl.sv
// z80 memory-side bus slave: decodes MREQ_L/RD_L/WR_L cycles, inserts
// WAIT_CYCLES wait states and serves bytes from an internal RAM.
// Optional feature macro: Z80_MEM_ROM_PROTECT_EN blocks writes below ROM_TOP
// and raises the sticky rom_wr_err flag.
module z80_mem_ctrl
    import z80_pkg::*;
#(
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter logic [15:0] ROM_TOP     = ROM_TOP_DEF
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic [15:0] addr,
    input  logic [7:0]  data_wr,
    output logic [7:0]  data_rd,
    output logic        data_oe,
    input  logic        MREQ_L,
    input  logic        RD_L,
    input  logic        WR_L,
    input  logic        RFSH_L,
    output logic        WAIT_L,
    output logic        rom_wr_err
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam bit          HAS_WAIT  = (WAIT_CYCLES != 0);
    localparam logic [3:0]  WAIT_INIT = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    mem_state_t    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    mem_dir_t      dir_q, dir_d;
    logic          wait_l_q, wait_l_d;
    logic          oe_q, oe_d;
    logic [7:0]    data_rd_q, data_rd_d;
    logic          armed_q, armed_d;

    logic          req_s;
    logic          strobe_rel_s;
    logic          wr_ok_s;
    logic          ram_we_s;
    logic [AW-1:0] ram_addr_s;
    logic [7:0]    ram_rdata_s;
    logic          unused_s;

`ifdef Z80_MEM_ROM_PROTECT_EN
    logic          prot_q, prot_d;
    logic          err_q, err_d;
    assign wr_ok_s    = ~prot_q;
    assign rom_wr_err = err_q;
`else
    assign wr_ok_s    = 1'b1;
    assign rom_wr_err = 1'b0;
`endif

    // armed_q blocks re-detection of strobes left low until MREQ_L is seen high
    assign req_s        = (state_q == IDLE) & armed_q & ~MREQ_L & RFSH_L & (~RD_L | ~WR_L);
    assign strobe_rel_s = (dir_q == DIR_RD) ? RD_L : WR_L;
    assign ram_addr_s   = (state_q == IDLE) ? addr[AW-1:0] : addr_q;
    assign ram_we_s     = (state_q == XFER) & (dir_q == DIR_WR) & ~MREQ_L & wr_ok_s;
    assign unused_s     = ^{addr, ROM_TOP};

    z80_mem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we_i    (ram_we_s),
        .addr_i  (ram_addr_s),
        .wdata_i (data_wr),
        .rdata_o (ram_rdata_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; MREQ_L rising aborts WAIT/XFER
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_s) state_d = HAS_WAIT ? WAIT : XFER;
                else       state_d = IDLE;
            end
            WAIT: begin
                if (MREQ_L)              state_d = IDLE;
                else if (cnt_q == 4'd0)  state_d = XFER;
                else                     state_d = WAIT;
            end
            XFER: begin
                if (MREQ_L) state_d = IDLE;
                else        state_d = HOLD;
            end
            HOLD: begin
                if (MREQ_L || strobe_rel_s) state_d = IDLE;
                else                        state_d = HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values per state
    always_comb begin
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        dir_d     = dir_q;
        wait_l_d  = wait_l_q;
        oe_d      = oe_q;
        data_rd_d = data_rd_q;
`ifdef Z80_MEM_ROM_PROTECT_EN
        prot_d    = prot_q;
        err_d     = err_q;
`endif
        if (MREQ_L)     armed_d = 1'b1;
        else if (req_s) armed_d = 1'b0;
        else            armed_d = armed_q;

        case (state_q)
            IDLE: begin
                if (req_s) begin
                    addr_d = addr[AW-1:0];
                    dir_d  = RD_L ? DIR_WR : DIR_RD;
`ifdef Z80_MEM_ROM_PROTECT_EN
                    prot_d = (addr < ROM_TOP);
`endif
                    if (HAS_WAIT) begin
                        wait_l_d = 1'b0;
                        cnt_d    = WAIT_INIT;
                    end else begin
                        wait_l_d = 1'b1;
                    end
                end else begin
                    oe_d = 1'b0;
                end
            end
            WAIT: begin
                if (MREQ_L || (cnt_q == 4'd0)) begin
                    wait_l_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            XFER: begin
                if (MREQ_L) begin
                    oe_d = 1'b0;
                end else if (dir_q == DIR_RD) begin
                    data_rd_d = ram_rdata_s;
                    oe_d      = 1'b1;
                end else begin
`ifdef Z80_MEM_ROM_PROTECT_EN
                    if (prot_q) err_d = 1'b1;
                    else        err_d = err_q;
`endif
                    oe_d = 1'b0;
                end
            end
            HOLD: begin
                if (MREQ_L || strobe_rel_s) oe_d = 1'b0;
                else                        oe_d = oe_q;
            end
            default: begin
                wait_l_d = 1'b1;
                oe_d     = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            dir_q     <= DIR_RD;
            wait_l_q  <= 1'b1;
            oe_q      <= 1'b0;
            data_rd_q <= 8'h00;
            armed_q   <= 1'b1;
`ifdef Z80_MEM_ROM_PROTECT_EN
            prot_q    <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            dir_q     <= dir_d;
            wait_l_q  <= wait_l_d;
            oe_q      <= oe_d;
            data_rd_q <= data_rd_d;
            armed_q   <= armed_d;
`ifdef Z80_MEM_ROM_PROTECT_EN
            prot_q    <= prot_d;
            err_q     <= err_d;
`endif
        end
    end

    assign WAIT_L  = wait_l_q;
    assign data_oe = oe_q;
    assign data_rd = data_rd_q;

endmodule

// File: tb/tb_z80_mem_ctrl.sv
// Directed bench for z80_mem_ctrl. Three instances share the bus except for
// MREQ_L, so each scenario talks to exactly one instance:
//   idx 0: WAIT_CYCLES=0, ROM_TOP=0 (never protected)
//   idx 1: WAIT_CYCLES=2
//   idx 2: WAIT_CYCLES=3
module tb_z80_mem_ctrl;

`ifdef Z80_MEM_ROM_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_L;
    logic [15:0]     addr;
    logic [7:0]      data_wr;
    logic [2:0]      mreq_l;
    logic            RD_L, WR_L, RFSH_L;
    logic [2:0][7:0] drd_v;
    logic [2:0]      oe_v, wait_v, err_v;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    z80_mem_ctrl #(.DEPTH(16384), .WAIT_CYCLES(0), .ROM_TOP(16'h0000)) u_d0 (
        .clk(clk), .rst_L(rst_L), .addr(addr), .data_wr(data_wr),
        .data_rd(drd_v[0]), .data_oe(oe_v[0]), .MREQ_L(mreq_l[0]),
        .RD_L(RD_L), .WR_L(WR_L), .RFSH_L(RFSH_L),
        .WAIT_L(wait_v[0]), .rom_wr_err(err_v[0]));

    z80_mem_ctrl #(.DEPTH(16384), .WAIT_CYCLES(2)) u_d1 (
        .clk(clk), .rst_L(rst_L), .addr(addr), .data_wr(data_wr),
        .data_rd(drd_v[1]), .data_oe(oe_v[1]), .MREQ_L(mreq_l[1]),
        .RD_L(RD_L), .WR_L(WR_L), .RFSH_L(RFSH_L),
        .WAIT_L(wait_v[1]), .rom_wr_err(err_v[1]));

    z80_mem_ctrl #(.DEPTH(16384), .WAIT_CYCLES(3)) u_d2 (
        .clk(clk), .rst_L(rst_L), .addr(addr), .data_wr(data_wr),
        .data_rd(drd_v[2]), .data_oe(oe_v[2]), .MREQ_L(mreq_l[2]),
        .RD_L(RD_L), .WR_L(WR_L), .RFSH_L(RFSH_L),
        .WAIT_L(wait_v[2]), .rom_wr_err(err_v[2]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access. Sample j is taken just after edge j, edge 0 being
    // the detect edge. Strobe is released first (oe_after sampled one edge
    // later), then MREQ_L.
    task automatic access(input int idx, input int wc, input bit wr,
                          input logic [15:0] a, input logic [7:0] d,
                          output int wcnt, output int oefirst,
                          output logic [7:0] rd, output logic oe_after);
        addr        = a;
        data_wr     = d;
        mreq_l[idx] = 1'b0;
        if (wr) WR_L = 1'b0;
        else    RD_L = 1'b0;
        wcnt    = 0;
        oefirst = -1;
        for (int j = 0; j <= wc + 4; j++) begin
            step();
            if (wait_v[idx] === 1'b0) wcnt++;
            if (oefirst < 0 && oe_v[idx] === 1'b1) oefirst = j;
        end
        rd   = drd_v[idx];
        RD_L = 1'b1;
        WR_L = 1'b1;
        step();
        oe_after    = oe_v[idx];
        mreq_l[idx] = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_L = 1'b0; mreq_l = 3'b111; RD_L = 1'b1; WR_L = 1'b1; RFSH_L = 1'b1;
        addr = 16'h0000; data_wr = 8'h00;
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({wait_v[i], oe_v[i], drd_v[i], err_v[i]} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_in dut%0d: wait=%b oe=%b rd=%h err=%b, expected 1 0 00 0",
                         i, wait_v[i], oe_v[i], drd_v[i], err_v[i]);
            end
        end
        rst_L = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if ({wait_v[i], oe_v[i], drd_v[i], err_v[i]} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
                    n_fail++;
                    $display("FAIL reset_idle dut%0d c%0d: wait=%b oe=%b rd=%h err=%b, expected 1 0 00 0",
                             i, c, wait_v[i], oe_v[i], drd_v[i], err_v[i]);
                end
            end
        end
    endtask

    task automatic test_wait_read();
        int wcnt, oef; logic [7:0] rd; logic oea;
        access(1, 2, 1'b1, 16'h4123, 8'hA5, wcnt, oef, rd, oea);
        n_tests++;
        if (wcnt !== 2) begin n_fail++; $display("FAIL w2_write_waits: got %0d expected 2", wcnt); end
        n_tests++;
        if (oef !== -1) begin n_fail++; $display("FAIL w2_write_oe: oe rose at %0d expected never", oef); end
        access(1, 2, 1'b0, 16'h4123, 8'h00, wcnt, oef, rd, oea);
        n_tests++;
        if (wcnt !== 2) begin n_fail++; $display("FAIL w2_read_waits: got %0d expected 2", wcnt); end
        n_tests++;
        if (oef !== 3) begin n_fail++; $display("FAIL w2_read_latency: got %0d expected 3", oef); end
        n_tests++;
        if (rd !== 8'hA5) begin n_fail++; $display("FAIL w2_read_data: got %h expected a5", rd); end
        n_tests++;
        if (oea !== 1'b0) begin n_fail++; $display("FAIL w2_oe_release: got %b expected 0", oea); end
        n_tests++;
        if (err_v[1] !== 1'b0) begin n_fail++; $display("FAIL w2_err: got %b expected 0", err_v[1]); end
    endtask

    task automatic test_mirror();
        int wcnt, oef; logic [7:0] rd; logic oea;
        access(0, 0, 1'b1, 16'h0010, 8'h3C, wcnt, oef, rd, oea);
        n_tests++;
        if (wcnt !== 0) begin n_fail++; $display("FAIL w0_write_waits: got %0d expected 0", wcnt); end
        n_tests++;
        if (oef !== -1) begin n_fail++; $display("FAIL w0_write_oe: oe rose at %0d expected never", oef); end
        access(0, 0, 1'b0, 16'h4010, 8'h00, wcnt, oef, rd, oea);
        n_tests++;
        if (wcnt !== 0) begin n_fail++; $display("FAIL w0_read_waits: got %0d expected 0", wcnt); end
        n_tests++;
        if (oef !== 1) begin n_fail++; $display("FAIL w0_read_latency: got %0d expected 1", oef); end
        n_tests++;
        if (rd !== 8'h3C) begin n_fail++; $display("FAIL mirror_data: got %h expected 3c", rd); end
    endtask

    task automatic test_refresh();
        addr = 16'h4123; mreq_l[1] = 1'b0; RFSH_L = 1'b0; RD_L = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) RD_L = 1'b0;
            step();
            n_tests++;
            if ({wait_v[1], oe_v[1], drd_v[1]} !== {1'b1, 1'b0, 8'hA5}) begin
                n_fail++;
                $display("FAIL refresh c%0d: wait=%b oe=%b rd=%h expected 1 0 a5",
                         c, wait_v[1], oe_v[1], drd_v[1]);
            end
        end
        RD_L = 1'b1; RFSH_L = 1'b1; mreq_l[1] = 1'b1;
        step();
    endtask

    task automatic test_abort();
        int wcnt, oef; logic [7:0] rd; logic oea;
        access(2, 3, 1'b1, 16'h5000, 8'h77, wcnt, oef, rd, oea);
        n_tests++;
        if (wcnt !== 3) begin n_fail++; $display("FAIL w3_write_waits: got %0d expected 3", wcnt); end
        addr = 16'h5000; data_wr = 8'h99; mreq_l[2] = 1'b0; WR_L = 1'b0;
        step();
        n_tests++;
        if (wait_v[2] !== 1'b0) begin n_fail++; $display("FAIL abort_wait_low: got %b expected 0", wait_v[2]); end
        mreq_l[2] = 1'b1;
        step();
        n_tests++;
        if (wait_v[2] !== 1'b1) begin n_fail++; $display("FAIL abort_wait_high: got %b expected 1", wait_v[2]); end
        WR_L = 1'b1;
        repeat (4) step();
        n_tests++;
        if ({wait_v[2], oe_v[2]} !== 2'b10) begin
            n_fail++; $display("FAIL abort_idle: wait=%b oe=%b expected 1 0", wait_v[2], oe_v[2]);
        end
        access(2, 3, 1'b0, 16'h5000, 8'h00, wcnt, oef, rd, oea);
        n_tests++;
        if (rd !== 8'h77) begin n_fail++; $display("FAIL abort_data: got %h expected 77", rd); end
        n_tests++;
        if (oef !== 4) begin n_fail++; $display("FAIL w3_read_latency: got %0d expected 4", oef); end
    endtask

    task automatic test_rom();
        int wcnt, oef; logic [7:0] rd; logic oea;
        // 16'h4100 mirrors onto the same byte as 16'h0100 but is above ROM_TOP
        access(1, 2, 1'b1, 16'h4100, 8'h11, wcnt, oef, rd, oea);
        n_tests++;
        if (err_v[1] !== 1'b0) begin n_fail++; $display("FAIL rom_err_pre: got %b expected 0", err_v[1]); end
        access(1, 2, 1'b1, 16'h0100, 8'hFF, wcnt, oef, rd, oea);
        n_tests++;
        if (wcnt !== 2) begin n_fail++; $display("FAIL rom_write_waits: got %0d expected 2", wcnt); end
        n_tests++;
        if (err_v[1] !== PROT) begin n_fail++; $display("FAIL rom_err_set: got %b expected %b", err_v[1], PROT); end
        repeat (3) step();
        access(1, 2, 1'b0, 16'h0100, 8'h00, wcnt, oef, rd, oea);
        n_tests++;
        if (rd !== (PROT ? 8'h11 : 8'hFF)) begin
            n_fail++; $display("FAIL rom_data: got %h expected %h", rd, PROT ? 8'h11 : 8'hFF);
        end
        n_tests++;
        if (err_v[1] !== PROT) begin n_fail++; $display("FAIL rom_err_sticky: got %b expected %b", err_v[1], PROT); end
    endtask

    task automatic test_back_to_back();
        int wcnt, oef; logic [7:0] rd; logic oea;
        addr = 16'h4123; mreq_l[1] = 1'b0; RD_L = 1'b0;
        repeat (5) step();
        n_tests++;
        if ({oe_v[1], drd_v[1]} !== {1'b1, 8'hA5}) begin
            n_fail++; $display("FAIL b2b_first: oe=%b rd=%h expected 1 a5", oe_v[1], drd_v[1]);
        end
        RD_L = 1'b1;
        step();
        RD_L = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            n_tests++;
            if ({wait_v[1], oe_v[1]} !== 2'b10) begin
                n_fail++; $display("FAIL b2b_no_redetect c%0d: wait=%b oe=%b expected 1 0", c, wait_v[1], oe_v[1]);
            end
        end
        RD_L = 1'b1; mreq_l[1] = 1'b1;
        step();
        access(1, 2, 1'b0, 16'h4123, 8'h00, wcnt, oef, rd, oea);
        n_tests++;
        if ({wcnt, oef} !== {32'sd2, 32'sd3} || rd !== 8'hA5) begin
            n_fail++; $display("FAIL b2b_rearm: waits=%0d lat=%0d rd=%h expected 2 3 a5", wcnt, oef, rd);
        end
    endtask

    initial begin
        test_reset();
        test_wait_read();
        test_mirror();
        test_refresh();
        test_abort();
        test_rom();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/z80_mem_ctrl.md
Name: z80_mem_ctrl

Overview:
- Memory-side bus slave directly downstream of the z80 core on its address/data bus.
- Decodes MREQ_L/RD_L/WR_L cycles and serves them from an internal byte RAM.
- Inserts a programmable number of wait states through WAIT_L.
- Drives read data onto the shared data bus through an output-enable; the top-level tristate is built from data_oe.

Parameters:
- DEPTH, 16384, RAM size in bytes; power of 2, at most 65536; addresses mirror modulo DEPTH.
- WAIT_CYCLES, 1, WAIT_L-low cycles inserted per access; 0 to 15.
- ROM_TOP, 16'h4000, first writable address; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_L  in  1  asynchronous active-low reset
- addr  in  16  CPU address bus
- data_wr  in  8  data bus value driven by the CPU
- data_rd  out  8  read data toward the CPU
- data_oe  out  1  1 = controller drives data_rd onto the data bus
- MREQ_L  in  1  memory request, active low
- RD_L  in  1  read strobe, active low
- WR_L  in  1  write strobe, active low
- RFSH_L  in  1  refresh cycle, active low
- WAIT_L  out  1  wait request to CPU, active low, registered
- rom_wr_err  out  1  sticky blocked-write flag; constant 0 without the optional feature

Behaviour:
- Reset (async, rst_L=0): state=IDLE, WAIT_L=1, data_oe=0, data_rd=8'h00, rom_wr_err=0. RAM contents are not reset.
- Request detect, in IDLE only: MREQ_L=0 and RFSH_L=1 and (RD_L=0 or WR_L=0).
  - Latch addr[log2(DEPTH)-1:0] and the direction.
  - If RD_L and WR_L are both low, treat as a read.
- Refresh cycles (RFSH_L=0) are ignored entirely.
- States:
  - IDLE: on detect with WAIT_CYCLES>0, go to WAIT, set WAIT_L<=0, cnt<=WAIT_CYCLES-1. On detect with WAIT_CYCLES=0, go directly to XFER.
  - WAIT: when cnt=0, set WAIT_L<=1 and go to XFER. Otherwise decrement cnt.
  - XFER (one cycle):
    - Read: data_rd<=mem[latched addr], data_oe<=1.
    - Write: mem[latched addr]<=data_wr sampled this cycle.
    - Then go to HOLD.
  - HOLD: data_oe and data_rd remain stable. When MREQ_L=1, or the active strobe (RD_L for a read, WR_L for a write) is 1, set data_oe<=0 and go to IDLE.
- Latency:
  - Read data is valid, with data_oe=1, on the clock edge WAIT_CYCLES+1 cycles after the detect edge.
  - WAIT_L is low for exactly WAIT_CYCLES cycles.
- Abort: MREQ_L rising during WAIT or XFER forces IDLE, WAIT_L<=1, data_oe<=0. An aborted write does not update memory.
- Back-to-back accesses: a new access needs at least one IDLE cycle. Strobes still low in IDLE after HOLD are not re-detected until MREQ_L has been seen high.
- Address wrap: addr>=DEPTH maps to addr mod DEPTH.
- WAIT_L is never low outside WAIT.
- data_oe is never 1 during a write or in IDLE.

Optional Feature:
- Macro: Z80_MEM_ROM_PROTECT_EN.
- Defined:
  - Writes whose full 16-bit addr is below ROM_TOP are completed in bus timing (same WAIT_L and HOLD sequence) but do not modify memory.
  - Such a write sets rom_wr_err=1. The flag is sticky until reset.
- Undefined: all addresses are writable and rom_wr_err is tied to 0.

Decomposition:
- Shared package z80_pkg holds:
  - the state enum mem_state_t {IDLE, WAIT, XFER, HOLD};
  - the access-direction enum;
  - the default WAIT_CYCLES and ROM_TOP constants.
- One sub-module, z80_mem_ram: a single-port synchronous byte RAM with write enable and registered read, DEPTH-parameterised.
- The FSM, counter and bus decode remain in z80_mem_ctrl.

Test Plan:
- Reset release with bus idle -> WAIT_L=1, data_oe=0, data_rd=00, and all remain so for 10 cycles.
- WAIT_CYCLES=2; write 8'hA5 to 16'h4123, then read 16'h4123 -> WAIT_L low for exactly 2 cycles per access; read shows data_oe=1, data_rd=A5 on the 3rd edge after detect; data_oe falls 1 cycle after RD_L rises.
- WAIT_CYCLES=0, DEPTH=16384; write 8'h3C to 16'h0010, then read 16'h4010 -> no WAIT_L pulse; read returns 3C (mirror).
- Refresh cycle with MREQ_L=0, RFSH_L=0, RD_L=1 -> no state change, WAIT_L stays 1, data_oe stays 0.
- WAIT_CYCLES=3; write to 16'h5000 with MREQ_L raised during WAIT -> WAIT_L returns to 1 next cycle; a subsequent read of 16'h5000 returns the old contents.
- With Z80_MEM_ROM_PROTECT_EN: write 8'hFF to 16'h0100 (old value 8'h11) -> rom_wr_err=1 and stays set; a read of 16'h0100 returns 11. Without the macro the same write succeeds and rom_wr_err stays 0.
